conv_line_sched: RTL

Frame-level scheduler for the 3x3 convolution engine. It writes incoming RGB pixels (3 x 8-bit per word) into four rotating line-buffer RAMs. It starts one convolution row pass whenever three complete input lines are resident, and it stalls the pixel source so that a line still needed by the engine is never overwritten. It sits between the pixel source and `conv_layer`, drives the RAM write ports and `start_rd`, and consumes `fin_rd`.

---
 rtl/conv_line_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/conv_line_sched.sv
// Frame scheduler for the 3x3 convolution engine: fills four rotating line RAMs
// and launches one row pass whenever a full 3-line window is resident.
module conv_line_sched #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [23:0]       pix_in,
    output logic              pix_ready,
    output logic [3:0]        wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              start_rd,
    output logic [1:0]        rd_sel,
    input  logic              fin_rd,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic R_WAIT = 1'b0;
    localparam logic R_BUSY = 1'b1;

    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] ROWS_IN  = ADDR_W'(IMG_H);
    localparam logic [ADDR_W-1:0] ROWS_OUT = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] THREE    = ADDR_W'(3);

    logic [1:0]        state_q,    state_d;
    logic              rstate_q,   rstate_d;
    logic [ADDR_W-1:0] wr_col_q,   wr_col_d;
    logic [ADDR_W-1:0] wr_row_q,   wr_row_d;
    logic [ADDR_W-1:0] rd_row_q,   rd_row_d;
    logic [3:0]        wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [23:0]       wr_data_q,  wr_data_d;
    logic              start_rd_q, start_rd_d;
    logic [1:0]        rd_sel_q,   rd_sel_d;

    logic              accept;

    // Guard uses the registered rd_row, so a buffer freed by fin_rd opens one cycle later.
    assign pix_ready = (state_q == S_RUN) && (wr_row_q < ROWS_IN) &&
                       (wr_row_q <= rd_row_q + THREE);
    assign accept    = pix_valid && pix_ready;

    always_comb begin
        state_d    = state_q;
        rstate_d   = rstate_q;
        wr_col_d   = wr_col_q;
        wr_row_d   = wr_row_q;
        rd_row_d   = rd_row_q;
        wr_en_d    = '0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        start_rd_d = start_rd_q;
        rd_sel_d   = rd_sel_q;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d    = S_RUN;
                    rstate_d   = R_WAIT;
                    wr_col_d   = '0;
                    wr_row_d   = '0;
                    rd_row_d   = '0;
                    start_rd_d = 1'b0;
                end
            end
            S_RUN: begin
                if (rd_row_q == ROWS_OUT) begin
                    state_d = S_DONE;
                end

                if (accept) begin
                    wr_en_d   = 4'b0001 << wr_row_q[1:0];
                    wr_addr_d = wr_col_q;
                    wr_data_d = pix_in;
                    if (wr_col_q == COL_LAST) begin
                        wr_col_d = '0;
                        wr_row_d = wr_row_q + 1'b1;
                    end else begin
                        wr_col_d = wr_col_q + 1'b1;
                    end
                end

                if (rstate_q == R_WAIT) begin
                    if ((wr_row_q >= rd_row_q + THREE) && (rd_row_q < ROWS_OUT)) begin
                        start_rd_d = 1'b1;
                        rd_sel_d   = rd_row_q[1:0];
                        rstate_d   = R_BUSY;
                    end
                end else if (fin_rd) begin
                    start_rd_d = 1'b0;
                    rd_row_d   = rd_row_q + 1'b1;
                    rstate_d   = R_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            rstate_q   <= R_WAIT;
            wr_col_q   <= '0;
            wr_row_q   <= '0;
            rd_row_q   <= '0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            start_rd_q <= 1'b0;
            rd_sel_q   <= '0;
        end else begin
            state_q    <= state_d;
            rstate_q   <= rstate_d;
            wr_col_q   <= wr_col_d;
            wr_row_q   <= wr_row_d;
            rd_row_q   <= rd_row_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            start_rd_q <= start_rd_d;
            rd_sel_q   <= rd_sel_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign start_rd   = start_rd_q;
    assign rd_sel     = rd_sel_q;
    assign busy       = (state_q == S_RUN);
    assign frame_done = (state_q == S_DONE);

endmodule
